// File: rtl/div_pkg.sv
// div_pkg: shared widths, divider FSM states and control constants.
//   RegBus / DoubleRegBus : operand and result widths
//   div_state_e           : divider FSM states
//   DivStart / DivStop    : start_i levels
//   DivResultReady / DivResultNotReady : ready_o levels
package div_pkg;
  localparam int RegBus = 32;
  localparam int DoubleRegBus = 64;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
endpackage

// File: rtl/div.sv
// div: multi-cycle restoring divider, one quotient bit per clock.
//   clk, rst (async active-low)
//   signed_div_i  : 1 = signed, 0 = unsigned
//   opdata1_i/2_i : dividend / divisor, latched on acceptance
//   start_i       : request, held until ready_o is seen
//   annul_i       : cancel the operation in flight
//   result_o      : {remainder, quotient}
//   ready_o       : result valid, held until start_i drops
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);
  div_state_e state, state_d;
  logic [5:0] cnt, cnt_d;
  logic [64:0] d, d_d;
  logic [RegBus-1:0] dvs, dvs_d;
  logic sgn, sgn_d, s1, s1_d, s2, s2_d;
  logic [DoubleRegBus-1:0] result_d;
  logic ready_d;
  logic [RegBus-1:0] abs1, abs2, quo, rem;
  logic [RegBus:0] t;
  assign abs1 = (signed_div_i && opdata1_i[RegBus-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[RegBus-1]) ? -opdata2_i : opdata2_i;
  assign t = {1'b0, d[63:32]} - {1'b0, dvs};
  // Sign fix-up: quotient follows the sign product, remainder the dividend.
  assign quo = (sgn && (s1 ^ s2)) ? -d[31:0] : d[31:0];
  assign rem = (sgn && s1) ? -d[64:33] : d[64:33];
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    d_d = d;
    dvs_d = dvs;
    sgn_d = sgn;
    s1_d = s1;
    s2_d = s2;
    result_d = result_o;
    ready_d = ready_o;
    case (state)
      DivFree: if (start_i == DivStart && !annul_i) begin
        state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        cnt_d = '0;
        d_d = {32'b0, abs1, 1'b0};
        dvs_d = abs2;
        sgn_d = signed_div_i;
        s1_d = opdata1_i[RegBus-1];
        s2_d = opdata2_i[RegBus-1];
      end
      DivByZero: begin
        d_d = '0;
        result_d = '0;
        state_d = DivEnd;
      end
      DivOn: if (annul_i) begin
        state_d = DivFree;
        cnt_d = '0;
      end else if (cnt != 6'd32) begin
        d_d = t[RegBus] ? {d[63:0], 1'b0} : {t[31:0], d[31:0], 1'b1};
        cnt_d = cnt + 6'd1;
      end else begin
        result_d = {rem, quo};
        ready_d = DivResultReady;
        cnt_d = '0;
        state_d = DivEnd;
      end
      default: if (start_i == DivStop) begin
        state_d = DivFree;
        ready_d = DivResultNotReady;
        result_d = '0;
      end else begin
        // Divide-by-zero arrives here with result already cleared.
        ready_d = DivResultReady;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DivFree;
      cnt <= '0;
      d <= '0;
      dvs <= '0;
      sgn <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      result_o <= '0;
      ready_o <= DivResultNotReady;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      d <= d_d;
      dvs <= dvs_d;
      sgn <= sgn_d;
      s1 <= s1_d;
      s2 <= s2_d;
      result_o <= result_d;
      ready_o <= ready_d;
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the multi-cycle divider.
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  div dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = {32'h0, a};
      y = {32'h0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one request; n counts edges including the accepting edge until ready_o.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [63:0] res);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~s;
      end
    end while (!ready_o && n < 60);
    res = result_o;
  endtask

  task automatic release_op();
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    #12 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_basic();
    int n;
    logic [63:0] res, exp;
    sb.push_back(model(1'b0, 32'd100, 32'd7));
    run_op(1'b0, 32'd100, 32'd7, n, res);
    exp = sb.pop_front();
    vectors++;
    if (n !== 34) begin
      miscompares++;
      $display("FAIL latency_100_7: got %0d edges, want 34", n);
    end
    vectors++;
    if (res !== exp || res !== {32'h2, 32'hE}) begin
      miscompares++;
      $display("FAIL result_100_7: got %h, want %h", res, exp);
    end
    annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    annul_i = 1'b0;
    vectors++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      miscompares++;
      $display("FAIL hold_in_end: ready=%b result=%h, want 1/%h", ready_o, result_o, exp);
    end
    release_op();
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL release: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_directed();
    logic s_t[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_t[6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd5, 32'd5, 32'h7FFFFFFF};
    logic [31:0] b_t[6] = '{32'h2, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000};
    logic [63:0] r_t[6] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'h7FFFFFFC},
                            {32'h0, 32'h80000000}, 64'h0, 64'h0, {32'h7FFFFFFF, 32'h0}};
    int n;
    logic [63:0] res, exp;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(s_t[i], a_t[i], b_t[i]));
      run_op(s_t[i], a_t[i], b_t[i], n, res);
      exp = sb.pop_front();
      vectors++;
      if (n !== ((b_t[i] == 0) ? 3 : 34)) begin
        miscompares++;
        $display("FAIL latency_dir%0d: got %0d edges", i, n);
      end
      vectors++;
      if (res !== exp || res !== r_t[i]) begin
        miscompares++;
        $display("FAIL result_dir%0d: got %h, want %h", i, res, r_t[i]);
      end
      release_op();
    end
  endtask

  task automatic test_annul();
    int n;
    logic [63:0] res, exp;
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_mid: ready=%b, want 0", ready_o);
    end
    sb.push_back(model(1'b0, 32'd9, 32'd3));
    run_op(1'b0, 32'd9, 32'd3, n, res);
    exp = sb.pop_front();
    vectors++;
    if (n !== 34 || res !== exp) begin
      miscompares++;
      $display("FAIL after_annul: %0d edges result %h, want 34 edges %h", n, res, exp);
    end
    release_op();
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL annul_final: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [63:0] res, exp;
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (21) @(posedge clk);
    start_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    #20 rst = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(1'b0, 32'd100, 32'd7));
    run_op(1'b0, 32'd100, 32'd7, n, res);
    exp = sb.pop_front();
    vectors++;
    if (n !== 34 || res !== exp) begin
      miscompares++;
      $display("FAIL after_reset: %0d edges result %h, want 34 edges %h", n, res, exp);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_in_end: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int n;
    logic s;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    for (int i = 0; i < 16; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom >> $urandom_range(0, 31);
      if (i == 5) a = 32'h0;
      sb.push_back(model(s, a, b));
      run_op(s, a, b, n, res);
      exp = sb.pop_front();
      vectors++;
      if (n !== ((b == 0) ? 3 : 34) || res !== exp) begin
        miscompares++;
        $display("FAIL b2b%0d s=%b %h/%h: %0d edges result %h, want %h", i, s, a, b, n, res, exp);
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_directed();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div.md
# div

- Multi-cycle 32-bit divider responding to execute-stage div/divu requests.
- Sits beside the execute stage:
  - Execute issues operands with a start request and stalls the pipeline.
  - This block computes the result one quotient bit per clock, then raises ready with the 64-bit result.
  - Execute writes {remainder, quotient} to HI/LO.
- Supports signed and unsigned operation, cancellation, and divide-by-zero.

## Interface
Parameters: none. Widths come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).

Reset: one clock; reset is asynchronous and active-low.

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- signed_div_i  input  1  1 = signed division (div), 0 = unsigned (divu)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request from execute; held high until ready_o is seen
- annul_i  input  1  cancel the in-progress operation
- result_o  output  64  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid; held while in DivEnd

## Operation
States:
- DivFree
- DivByZero
- DivOn
- DivEnd
- Iteration counter cnt is 6 bits.

Transitions:
- **DivFree**: if start_i=1 and annul_i=0:
  - opdata2_i==0 → DivByZero.
  - Otherwise latch the operands, cnt=0 → DivOn.
  - Operands are converted to magnitudes when signed_div_i=1 and the sign bit is set.
  - signed_div_i and both operand signs are latched at this point.
- **DivByZero**: dividend register cleared → DivEnd.
- **DivOn**:
  - If annul_i=1 → DivFree, no result.
  - Otherwise, while cnt<32, perform one iteration per cycle.
  - Iteration uses a 65-bit dividend register D, initialised to {32'b0, |op1|, 1'b0}.
  - t = {1'b0, D[63:32]} − {1'b0, |op2|}.
  - If t[32]=1: D ← D<<1.
  - Else: D ← {t[31:0], D[31:0], 1'b1}.
  - cnt increments each iteration.
  - When cnt==32: finalise and go → DivEnd.
    - Quotient = D[31:0].
    - Remainder = D[64:33].
    - Signed mode: negate the quotient if the operand signs differ.
    - Signed mode: negate the remainder if the dividend was negative.
  - Finalised values are registered into result_o, and ready_o is set to 1.
- **DivEnd**:
  - Hold result_o and ready_o.
  - When start_i=0 → DivFree, with ready_o=0 and result_o=0.
- start_i in any state other than DivFree is ignored as a new request.
- Operand inputs are ignored after they are latched.
- Arithmetic is two's-complement with wrap. Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. No exception is raised.
- Divide by zero yields result_o = 0 in both modes.

## Timing
- Reset (asynchronous, any state, including mid-operation):
  - state = DivFree, cnt = 0, D = 0.
  - result_o = 64'h0, ready_o = 0.
  - Any in-flight operation is lost.
- Let E0 be the edge that samples start_i=1 in DivFree.
  - Normal division: E1..E32 perform the 32 iterations, E33 finalises. ready_o is high after E33, so latency is 34 edges including E0.
  - Divide by zero: ready_o is high after E2.
- ready_o stays high until the first edge that samples start_i=0 in DivEnd, and falls on that edge.
- Back-to-back operations: a new start_i=1 is accepted at the earliest on the edge after the return to DivFree.
- annul_i has priority over start_i in DivFree and DivOn. In DivEnd, annul_i is ignored and only start_i=0 releases the block.
- Simultaneous annul_i=1 and the final iteration edge: annul wins, no ready_o is produced.

## Structure
- State and control constants go in the shared defines file:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
- The execute stage and the control module reference these constants.
- No sub-module is needed: a single state-machine always block plus a combinational subtract/abs datapath.

## Test plan
- Unsigned 100 / 7: start held high → ready_o rises 34 edges after E0, result_o = {32'h2, 32'hE}; after start drops, ready_o=0 and result_o=0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also unsigned 0xFFFFFFF9 / 2 → {32'h1, 32'h7FFFFFFC}.
- Divide by zero, 5 / 0, signed → ready_o high after E2, result_o = 64'h0.
- Signed 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}.
- annul_i pulsed at iteration 10 → DivFree on the next edge, ready_o never rises. An immediate new request 9 / 3 → {32'h0, 32'h3} on schedule.
- rst asserted at iteration 20 → outputs zero immediately (asynchronous). After release, a new 100 / 7 completes correctly.
